// File: rtl/mips_data_mem_if.sv
// mips_data_mem_if: bus between the mips core MEMORY stage, the console
// consumer, and mips_data_mem.
//   rd_wr    : 1 = read, 0 = write
//   addr     : byte address (bits [1:0] ignored)
//   wdata    : write data
//   rdata    : registered read data (valid the cycle after the access)
//   tx_data  : console FIFO head byte
//   tx_valid : console FIFO non-empty
//   tx_ready : consumer accepts tx_data this cycle
// master = core/consumer side, slave = memory side.
interface mips_data_mem_if;
    logic        rd_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output rd_wr, addr, wdata, tx_ready,
        input  rdata, tx_data, tx_valid
    );

    modport slave (
        input  rd_wr, addr, wdata, tx_ready,
        output rdata, tx_data, tx_valid
    );
endinterface

// File: rtl/mips_data_mem.sv
// mips_data_mem: single-port data RAM plus MMIO registers (cycle counter,
// console TX FIFO, FIFO status) for the mips core.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; clears rdata, counter, FIFO, overflow
//           (RAM contents are retained)
//   bus   : mips_data_mem_if.slave (core access port + console stream)
// MMIO map relative to MMIO_BASE: +0x0 CYCLE, +0x4 TX, +0x8 STATUS.
module mips_data_mem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 8
) (
    input logic             clk,
    input logic             reset,
    mips_data_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0] ram [DEPTH_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [31:0] cycle_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          overflow;

    // Decode on the word-aligned address; comparisons done in 33 bits so a
    // RAM window ending at the top of the address space cannot wrap.
    logic [31:0] word_addr;
    logic [32:0] ram_lo;
    logic [32:0] ram_hi;
    logic        ram_hit;
    logic        cyc_hit;
    logic        tx_hit;
    logic        st_hit;
    logic [AW-1:0] ram_idx;

    assign word_addr = {bus.addr[31:2], 2'b00};
    assign ram_lo    = {1'b0, RAM_BASE};
    assign ram_hi    = {1'b0, RAM_BASE} + 33'(4 * DEPTH_WORDS);
    assign ram_hit   = ({1'b0, word_addr} >= ram_lo) && ({1'b0, word_addr} < ram_hi);
    assign ram_idx   = AW'((word_addr - RAM_BASE) >> 2);
    assign cyc_hit   = !ram_hit && (word_addr == MMIO_BASE);
    assign tx_hit    = !ram_hit && (word_addr == MMIO_BASE + 32'd4);
    assign st_hit    = !ram_hit && (word_addr == MMIO_BASE + 32'd8);

    logic wr_en;
    assign wr_en = !reset && !bus.rd_wr;

    logic full;
    logic empty;
    logic pop;
    logic push_req;
    logic push_ok;

    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && bus.tx_ready;
    assign push_req = wr_en && tx_hit;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);

    assign bus.tx_valid = !empty;
    // Head is masked while empty so tx_data reads 0 after reset.
    assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    logic [31:0] status;
    always_comb begin
        status      = '0;
        status[7:0] = 8'(count);
        status[8]   = full;
        status[9]   = empty;
        status[16]  = overflow;
    end

    // Read mux uses pre-edge state, which also gives read-before-write.
    logic [31:0] rd_val;
    always_comb begin
        rd_val = '0;
        if (ram_hit)
            rd_val = ram[ram_idx];
        else if (cyc_hit)
            rd_val = cycle_cnt;
        else if (st_hit)
            rd_val = status;
    end

    always_ff @(posedge clk) begin
        if (wr_en && ram_hit)
            ram[ram_idx] <= bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rdata <= '0;
            cycle_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            bus.rdata <= rd_val;

            if (wr_en && cyc_hit)
                cycle_cnt <= bus.wdata;
            else
                cycle_cnt <= cycle_cnt + 32'd1;

            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (wr_en && st_hit && bus.wdata[16])
                overflow <= 1'b0;
        end
    end
endmodule
